salsa_core_param: RTL

SALSA_CORE_PARAM -- requirements
Module: salsa_core_param

---
 rtl/salsa_pkg.sv | 71 +++++++
 rtl/salsa_step.sv | 39 +++
 rtl/salsa_core_param.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/salsa_pkg.sv
// Shared Salsa20 core definitions: block geometry, FSM state encoding,
// rotation amounts and the per-step word index table.
// The table has 8 steps x 4 lanes. Each entry (tgt, src_a, src_b) means
// w[tgt] ^= rotl(w[src_a] + w[src_b], ROT_AMT[step % 4]).
// Steps 0-3 are the column round and steps 4-7 are the row round.
package salsa_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_WORDS = 16;
    localparam int unsigned BLK_W     = WORD_W * NUM_WORDS;
    localparam int unsigned NUM_STEPS = 8;
    localparam int unsigned NUM_LANES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Rotation by position within a round: entry 0 = 7, 1 = 9, 2 = 13, 3 = 18.
    localparam logic [3:0][4:0] ROT_AMT = {5'd18, 5'd13, 5'd9, 5'd7};

    typedef struct packed {
        logic [3:0] tgt;
        logic [3:0] src_a;
        logic [3:0] src_b;
    } step_idx_t;

    typedef step_idx_t [NUM_LANES-1:0] step_lanes_t;
    typedef step_lanes_t [NUM_STEPS-1:0] step_tab_t;

    // Word i sits at row i/4, column i%4. Lane l of a column step works down
    // column l starting at the diagonal. Lane l of a row step works along
    // row l starting at the diagonal. Step k within the round moves the
    // (b, a, tgt) window one position further.
    function automatic step_tab_t build_step_tab();
        step_tab_t tab;
        int        k;
        int        p_t;
        int        p_a;
        int        p_b;
        tab = '0;
        for (int s = 0; s < int'(NUM_STEPS); s++) begin
            for (int l = 0; l < int'(NUM_LANES); l++) begin
                k   = s % 4;
                p_t = (l + k + 1) % 4;
                p_a = (l + k) % 4;
                p_b = (l + k + 3) % 4;
                if (s < 4) begin
                    tab[s][l].tgt   = 4'(p_t * 4 + l);
                    tab[s][l].src_a = 4'(p_a * 4 + l);
                    tab[s][l].src_b = 4'(p_b * 4 + l);
                end else begin
                    tab[s][l].tgt   = 4'(l * 4 + p_t);
                    tab[s][l].src_a = 4'(l * 4 + p_a);
                    tab[s][l].src_b = 4'(l * 4 + p_b);
                end
            end
        end
        return tab;
    endfunction

    localparam step_tab_t STEP_TAB = build_step_tab();

    function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x,
                                                 input logic [4:0]        r);
        return (x << r) | (x >> (6'd32 - 6'(r)));
    endfunction

endpackage

// File: rtl/salsa_step.sv
// One combinational Salsa20 add-rotate-xor step: four independent lanes
// selected by the step index.
// Ports:
//   blk_in  - 512-bit state, word i at bits [32*(15-i) +: 32]
//   step    - step number 0-7 within the double round
//   blk_out - state after the step, same word mapping
module salsa_step
    import salsa_pkg::*;
(
    input  logic [BLK_W-1:0] blk_in,
    input  logic [2:0]       step,
    output logic [BLK_W-1:0] blk_out
);

    logic [WORD_W-1:0] w_in  [NUM_WORDS];
    logic [WORD_W-1:0] w_out [NUM_WORDS];

    // Word-array view of the packed block (word 0 is the most significant).
    for (genvar i = 0; i < int'(NUM_WORDS); i++) begin : g_word
        assign w_in[i] = blk_in[WORD_W*(NUM_WORDS-1-i) +: WORD_W];
        assign blk_out[WORD_W*(NUM_WORDS-1-i) +: WORD_W] = w_out[i];
    end

    // The four lanes of a step never read each other's targets, so every
    // source is taken from the unmodified input.
    always_comb begin
        w_out = w_in;
        for (int s = 0; s < int'(NUM_STEPS); s++) begin
            if (step == 3'(s)) begin
                for (int l = 0; l < int'(NUM_LANES); l++) begin
                    w_out[STEP_TAB[s][l].tgt] = w_in[STEP_TAB[s][l].tgt] ^
                        rotl32(w_in[STEP_TAB[s][l].src_a] + w_in[STEP_TAB[s][l].src_b],
                               ROT_AMT[s % 4]);
                end
            end
        end
    end

endmodule

// File: rtl/salsa_core_param.sv
// Iterative Salsa20/r core with valid/ready handshakes on both sides.
// Parameters:
//   NUM_ROUNDS      - rounds, even and >= 2
//   STEPS_PER_CYCLE - steps chained per clock: 1, 2, 4 or 8
//   FEED_FORWARD    - 1 adds the input block to the result, 0 = raw permutation
// Ports:
//   clk, n_rst          - clock, asynchronous active-low reset
//   in_valid/in_ready   - input handshake, in_data is the 512-bit block
//   out_valid/out_ready - output handshake, out_data is the 512-bit result
//   busy                - block in progress (RUN or FINAL)
module salsa_core_param
    import salsa_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS      = 8,
    parameter int unsigned STEPS_PER_CYCLE = 1,
    parameter int unsigned FEED_FORWARD    = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             busy
);

    // Reject unsupported configurations at elaboration.
    if (NUM_ROUNDS < 2 || (NUM_ROUNDS % 2) != 0) begin : g_bad_rounds
        $error("salsa_core_param: NUM_ROUNDS must be even and >= 2");
    end
    if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 &&
        STEPS_PER_CYCLE != 4 && STEPS_PER_CYCLE != 8) begin : g_bad_steps
        $error("salsa_core_param: STEPS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam int unsigned RUN_CYCLES = 4 * NUM_ROUNDS / STEPS_PER_CYCLE;
    localparam int unsigned CNT_W      = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);
    // Wraps to 0 for eight steps per cycle, which keeps the counter at 0.
    localparam logic [2:0] STEP_INC = 3'(STEPS_PER_CYCLE);

    state_e            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BLK_W-1:0]  work_q, work_d;
    logic [BLK_W-1:0]  saved_q, saved_d;
    logic [BLK_W-1:0]  out_q, out_d;
    logic              out_valid_q;
    logic              busy_q;
    logic              accept;
    logic [BLK_W-1:0]  run_next;
    logic [BLK_W-1:0]  final_c;

    // in_ready also opens in HOLD when the consumer takes the result, so a
    // new block can enter the same cycle the old one leaves.
    assign in_ready = (state_q == IDLE) || (state_q == HOLD && out_ready);
    assign accept   = in_valid && in_ready;

    // Combinational chain of STEPS_PER_CYCLE consecutive steps.
    for (genvar k = 0; k < int'(STEPS_PER_CYCLE); k++) begin : g_step
        logic [BLK_W-1:0] stage_in;
        logic [BLK_W-1:0] stage_out;
        if (k == 0) begin : g_first
            assign stage_in = work_q;
        end else begin : g_next
            assign stage_in = g_step[k-1].stage_out;
        end
        salsa_step u_step (
            .blk_in  (stage_in),
            .step    (step_q + 3'(k)),
            .blk_out (stage_out)
        );
    end
    assign run_next = g_step[STEPS_PER_CYCLE-1].stage_out;

    // Feed-forward: word-wise mod 2^32 add of the saved input.
    always_comb begin
        final_c = work_q;
        if (FEED_FORWARD != 0) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                final_c[WORD_W*i +: WORD_W] = work_q[WORD_W*i +: WORD_W] +
                                              saved_q[WORD_W*i +: WORD_W];
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        saved_d = saved_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = run_next;
                step_d = step_q + STEP_INC;
                if (cnt_q == CNT_LAST) begin
                    state_d = FINAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINAL: begin
                out_d   = final_c;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = accept ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Acceptance is only possible in IDLE or HOLD.
        if (accept) begin
            work_d  = in_data;
            saved_d = in_data;
            step_d  = '0;
            cnt_d   = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            work_q      <= '0;
            saved_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            saved_q     <= saved_d;
            out_q       <= out_d;
            out_valid_q <= (state_d == HOLD);
            busy_q      <= (state_d == RUN) || (state_d == FINAL);
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign busy      = busy_q;

endmodule
